// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller:
//   - state encoding of the receive FSM
//   - sample-point offset from the middle of a bit
//   - default oversampling ratio and its legal range
//   - legal_prescale(): maps an illegal ratio onto the default
// ---------------------------------------------------------------------------
package uart_rx_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;

   // The sampler's majority vote settles two oversample ticks after mid-bit.
   localparam int SP_OFFSET = 2;

   localparam int PRESCALE_DEF = 8;
   localparam int PRESCALE_MIN = 8;
   localparam int PRESCALE_MAX = 32;

   // Odd or out-of-range ratios fall back to the default.
   function automatic int legal_prescale(input int p);
      if ((p % 2 == 0) && (p >= PRESCALE_MIN) && (p <= PRESCALE_MAX))
         return p;
      return PRESCALE_DEF;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Strobe/error bundle between the RX controller and its helper blocks
// (sampler, deserializer, start/parity/stop checkers) plus the frame-level
// result strobes.
//   master (controller): drives enables and data_valid/frm_err,
//                        receives the registered error pulses.
//   slave  (helpers)   : the reverse.
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if;

   logic dat_samp_en;
   logic strt_chk_en;
   logic deser_en;
   logic par_chk_en;
   logic stp_chk_en;
   logic strt_glitch;
   logic par_err;
   logic stp_err;
   logic data_valid;
   logic frm_err;

   modport master (
      output dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
      output data_valid, frm_err,
      input  strt_glitch, par_err, stp_err
   );

   modport slave (
      input  dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
      input  data_valid, frm_err,
      output strt_glitch, par_err, stp_err
   );

endinterface

// File: rtl/uart_edge_bit_cnt.sv
// ---------------------------------------------------------------------------
// uart_edge_bit_cnt
// Oversample (edge) counter and bit counter for the RX controller.
//   clk, rst  : clock, asynchronous active-low reset
//   en        : advance edge_cnt by one
//   clr       : synchronous clear of both counters (wins over en)
//   p_lat     : latched oversampling ratio; edge_cnt wraps at p_lat-1
//   edge_cnt  : oversample index within the current bit
//   bit_cnt   : bit index, increments on each edge_cnt wrap
//   wrap      : high on the last oversample tick of a bit
// ---------------------------------------------------------------------------
module uart_edge_bit_cnt #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] p_lat,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  wrap
);

   assign wrap = (edge_cnt == p_lat - PRESCALE_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (clr) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (en) begin
         if (wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
         end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Sequencing FSM for the UART receive path.
//   clk, rst  : oversampled clock, asynchronous active-low reset
//   rx_in     : synchronised serial line, idle high
//   prescale  : oversampling ratio, latched at frame start
//   par_en    : parity bit present, latched at frame start
//   edge_cnt  : oversample index within the current bit
//   bit_cnt   : 0 = start, 1..DATA_WIDTH = data, then parity, then stop
//   busy      : FSM not in IDLE
//   bus       : helper enables, their error pulses, data_valid / frm_err
// ---------------------------------------------------------------------------
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  busy,
   uart_rx_ctrl_if.master        bus
);

   state_t                state, state_nxt;
   logic [PRESCALE_W-1:0] p_lat;
   logic [PRESCALE_W-1:0] sp;
   logic                  par_lat;
   logic                  glitch_f, err_f;
   logic                  last, cap;
   logic                  glitch_now, err_now;
   logic                  latch_cfg, cnt_en, cnt_clr;
   logic                  samp_en, strt_en, des_en, parc_en, stpc_en, dv, fe;

   assign sp  = (p_lat >> 1) + PRESCALE_W'(SP_OFFSET);
   assign cap = (edge_cnt == sp + PRESCALE_W'(1));

   // With the smallest ratio the capture tick coincides with the last tick
   // of the bit, so the decision must also see the error pulse arriving now.
   assign glitch_now = glitch_f | (cap & bus.strt_glitch);
   assign err_now    = err_f    | (cap & bus.stp_err);

   assign latch_cfg = ~rx_in & ((state == IDLE) | ((state == STOP) & last));
   assign cnt_en    = (state != IDLE);
   assign cnt_clr   = (state == IDLE) |
                      (last & ((state == STOP) | ((state == START) & glitch_now)));

   uart_edge_bit_cnt #(
      .PRESCALE_W (PRESCALE_W),
      .BIT_CNT_W  (BIT_CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (cnt_en),
      .clr      (cnt_clr),
      .p_lat    (p_lat),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt),
      .wrap     (last)
   );

   // Frame configuration, frozen for the whole frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_lat   <= '0;
         par_lat <= 1'b0;
      end else if (latch_cfg) begin
         p_lat   <= PRESCALE_W'(legal_prescale(int'(prescale)));
         par_lat <= par_en;
      end
   end

   // Sticky error flags, loaded only on the tick after each check strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         glitch_f <= 1'b0;
         err_f    <= 1'b0;
      end else if (cnt_clr) begin
         glitch_f <= 1'b0;
         err_f    <= 1'b0;
      end else if (cap) begin
         glitch_f <= glitch_f | ((state == START) & bus.strt_glitch);
         err_f    <= err_f | ((state == PARITY) & bus.par_err)
                           | ((state == STOP)   & bus.stp_err);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!rx_in) state_nxt = START;
         START:   if (last) state_nxt = glitch_now ? IDLE : DATA;
         DATA:    if (last && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                     state_nxt = par_lat ? PARITY : STOP;
         PARITY:  if (last) state_nxt = STOP;
         STOP:    if (last) state_nxt = rx_in ? IDLE : START;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      samp_en = (state != IDLE);
      strt_en = (state == START)  && (edge_cnt == sp);
      des_en  = (state == DATA)   && (edge_cnt == sp);
      parc_en = (state == PARITY) && (edge_cnt == sp);
      stpc_en = (state == STOP)   && (edge_cnt == sp);
      dv      = (state == STOP) && last && !err_now;
      fe      = (state == STOP) && last &&  err_now;
   end

   assign busy            = samp_en;
   assign bus.dat_samp_en = samp_en;
   assign bus.strt_chk_en = strt_en;
   assign bus.deser_en    = des_en;
   assign bus.par_chk_en  = parc_en;
   assign bus.stp_chk_en  = stpc_en;
   assign bus.data_valid  = dv;
   assign bus.frm_err     = fe;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl. Label T is the cycle in which the bench
// drops rx_in while the controller is idle; label T+k is observed k rising
// edges later. A frame driver plays the serial line and the helper checkers
// (error pulses one cycle after the matching enable) and records when each
// strobe appeared; each test task then compares against hand-derived cycles.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   localparam int DW   = 8;
   localparam int PW   = 6;
   localparam int BW   = 4;
   localparam int NREC = 200;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_in;
   logic          par_en;
   logic [PW-1:0] prescale;
   logic [PW-1:0] edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx_ctrl_if bus ();

   uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_in    (rx_in),
      .prescale (prescale),
      .par_en   (par_en),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt),
      .busy     (busy),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   bit busy_r [NREC];
   int edge_r [NREC];
   int deser_at [16];
   int strt_at, strt_n, par_at, par_n, stp_at, stp_n;
   int dv_at, dv_n, fe_at, fe_n, deser_n, samp_n;

   function automatic logic [17:0] out_vec();
      return {edge_cnt, bit_cnt, busy, bus.dat_samp_en, bus.strt_chk_en, bus.deser_en,
              bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.frm_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_frame(input int pres, input int p_eff, input bit pe, input logic [7:0] d,
                              input bit inj_g, input bit inj_p, input bit inj_s, input bit b2b,
                              input int nticks, input int chg_k, input int chg_val);
      int  total, b;
      bit  ps, pp, pst;
      logic line;
      total = p_eff * (10 + int'(pe));
      strt_at = -1; strt_n = 0; par_at = -1; par_n = 0; stp_at = -1; stp_n = 0;
      dv_at = -1; dv_n = 0; fe_at = -1; fe_n = 0; deser_n = 0; samp_n = 0;
      foreach (deser_at[i]) deser_at[i] = -1;
      foreach (busy_r[i]) begin busy_r[i] = 1'b0; edge_r[i] = -1; end
      prescale = PW'(pres);
      par_en   = pe;
      rx_in    = 1'b0;
      ps = 1'b0; pp = 1'b0; pst = 1'b0;
      for (int k = 1; k <= nticks && k < NREC; k++) begin
         @(posedge clk);
         #1;
         bus.strt_glitch = inj_g & ps;
         bus.par_err     = inj_p & pp;
         bus.stp_err     = inj_s & pst;
         if (k == chg_k) prescale = PW'(chg_val);
         b = k / p_eff;
         if (inj_g)                  line = 1'b1;
         else if (b2b && k == total) line = 1'b0;
         else if (b == 0)            line = 1'b0;
         else if (b <= DW)           line = d[b-1];
         else if (b == DW+1 && pe)   line = ^d;
         else                        line = 1'b1;
         rx_in = line;
         #1;
         busy_r[k] = busy;
         edge_r[k] = int'(edge_cnt);
         if (bus.strt_chk_en) begin if (strt_n == 0) strt_at = k; strt_n++; end
         if (bus.par_chk_en)  begin if (par_n == 0)  par_at  = k; par_n++;  end
         if (bus.stp_chk_en)  begin if (stp_n == 0)  stp_at  = k; stp_n++;  end
         if (bus.data_valid)  begin if (dv_n == 0)   dv_at   = k; dv_n++;   end
         if (bus.frm_err)     begin if (fe_n == 0)   fe_at   = k; fe_n++;   end
         if (bus.deser_en) begin if (deser_n < 16) deser_at[deser_n] = k; deser_n++; end
         if (bus.dat_samp_en) samp_n++;
         ps = bus.strt_chk_en; pp = bus.par_chk_en; pst = bus.stp_chk_en;
      end
      bus.strt_glitch = 1'b0;
      bus.par_err     = 1'b0;
      bus.stp_err     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; rx_in = 1'b0; prescale = 6'd8; par_en = 1'b0;
      bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
      #1;
      n_checks++; if (out_vec() !== 18'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", out_vec()); end
      tick(); tick();
      n_checks++; if (out_vec() !== 18'd0) begin n_fail++; $display("FAIL reset_held: got %h expected 0", out_vec()); end
      rx_in = 1'b1; rst = 1'b1;
      tick(); tick();
      n_checks++; if (busy !== 1'b0 || edge_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_idle: got busy=%b edge=%0d expected 0/0", busy, edge_cnt); end
   endtask

   task automatic test_basic();
      drive_frame(8, 8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 81, -1, 0);
      n_checks++; if (busy_r[1] !== 1'b1 || edge_r[1] != 0) begin n_fail++; $display("FAIL basic_enter: got busy=%b edge=%0d expected 1/0", busy_r[1], edge_r[1]); end
      n_checks++; if (strt_at != 7 || strt_n != 1) begin n_fail++; $display("FAIL basic_strt: got %0d (n=%0d) expected 7 (n=1)", strt_at, strt_n); end
      n_checks++; if (edge_r[8] != 7 || edge_r[9] != 0) begin n_fail++; $display("FAIL basic_wrap: got %0d,%0d expected 7,0", edge_r[8], edge_r[9]); end
      n_checks++; if (deser_n != 8) begin n_fail++; $display("FAIL basic_deser_n: got %0d expected 8", deser_n); end
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (deser_at[i] != 15 + 8*i) begin n_fail++; $display("FAIL basic_deser_%0d: got %0d expected %0d", i, deser_at[i], 15 + 8*i); end
      end
      n_checks++; if (par_n != 0) begin n_fail++; $display("FAIL basic_par_n: got %0d expected 0", par_n); end
      n_checks++; if (stp_at != 79 || stp_n != 1) begin n_fail++; $display("FAIL basic_stp: got %0d (n=%0d) expected 79 (n=1)", stp_at, stp_n); end
      n_checks++; if (dv_at != 80 || dv_n != 1) begin n_fail++; $display("FAIL basic_dv: got %0d (n=%0d) expected 80 (n=1)", dv_at, dv_n); end
      n_checks++; if (fe_n != 0) begin n_fail++; $display("FAIL basic_fe_n: got %0d expected 0", fe_n); end
      n_checks++; if (busy_r[80] !== 1'b1 || busy_r[81] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b,%b expected 1,0", busy_r[80], busy_r[81]); end
      n_checks++; if (samp_n != 80) begin n_fail++; $display("FAIL basic_samp_n: got %0d expected 80", samp_n); end
   endtask

   task automatic test_parity();
      drive_frame(16, 16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 177, -1, 0);
      n_checks++; if (par_at != 155 || dv_at != 176 || fe_n != 0) begin n_fail++; $display("FAIL par_good: got par=%0d dv=%0d fe_n=%0d expected 155/176/0", par_at, dv_at, fe_n); end
      drive_frame(16, 16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 177, -1, 0);
      n_checks++; if (strt_at != 11) begin n_fail++; $display("FAIL par_strt: got %0d expected 11", strt_at); end
      n_checks++; if (deser_n != 8 || deser_at[0] != 27) begin n_fail++; $display("FAIL par_deser: got n=%0d first=%0d expected 8/27", deser_n, deser_at[0]); end
      n_checks++; if (par_at != 155 || par_n != 1) begin n_fail++; $display("FAIL par_chk: got %0d (n=%0d) expected 155 (n=1)", par_at, par_n); end
      n_checks++; if (stp_at != 171) begin n_fail++; $display("FAIL par_stp: got %0d expected 171", stp_at); end
      n_checks++; if (fe_at != 176 || fe_n != 1) begin n_fail++; $display("FAIL par_fe: got %0d (n=%0d) expected 176 (n=1)", fe_at, fe_n); end
      n_checks++; if (dv_n != 0) begin n_fail++; $display("FAIL par_dv_n: got %0d expected 0", dv_n); end
      n_checks++; if (busy_r[176] !== 1'b1 || busy_r[177] !== 1'b0) begin n_fail++; $display("FAIL par_busy_end: got %b,%b expected 1,0", busy_r[176], busy_r[177]); end
   endtask

   task automatic test_stop_err();
      drive_frame(8, 8, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 81, -1, 0);
      n_checks++; if (fe_at != 80 || fe_n != 1) begin n_fail++; $display("FAIL stp_fe: got %0d (n=%0d) expected 80 (n=1)", fe_at, fe_n); end
      n_checks++; if (dv_n != 0 || busy_r[81] !== 1'b0) begin n_fail++; $display("FAIL stp_dv_busy: got dv_n=%0d busy=%b expected 0/0", dv_n, busy_r[81]); end
   endtask

   task automatic test_glitch();
      drive_frame(8, 8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 20, -1, 0);
      n_checks++; if (strt_at != 7) begin n_fail++; $display("FAIL glitch8_strt: got %0d expected 7", strt_at); end
      n_checks++; if (busy_r[8] !== 1'b1 || busy_r[9] !== 1'b0) begin n_fail++; $display("FAIL glitch8_abort: got %b,%b expected 1,0", busy_r[8], busy_r[9]); end
      n_checks++; if (deser_n != 0 || dv_n != 0 || fe_n != 0) begin n_fail++; $display("FAIL glitch8_quiet: got deser=%0d dv=%0d fe=%0d expected 0/0/0", deser_n, dv_n, fe_n); end
      drive_frame(16, 16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 30, -1, 0);
      n_checks++; if (busy_r[16] !== 1'b1 || busy_r[17] !== 1'b0) begin n_fail++; $display("FAIL glitch16_abort: got %b,%b expected 1,0", busy_r[16], busy_r[17]); end
      n_checks++; if (deser_n != 0 || dv_n != 0 || fe_n != 0) begin n_fail++; $display("FAIL glitch16_quiet: got deser=%0d dv=%0d fe=%0d expected 0/0/0", deser_n, dv_n, fe_n); end
      drive_frame(8, 8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 81, -1, 0);
      n_checks++; if (dv_at != 80 || deser_n != 8) begin n_fail++; $display("FAIL glitch_recover: got dv=%0d deser=%0d expected 80/8", dv_at, deser_n); end
   endtask

   task automatic test_back_to_back();
      drive_frame(8, 8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 80, -1, 0);
      n_checks++; if (dv_at != 80 || dv_n != 1) begin n_fail++; $display("FAIL b2b_dv1: got %0d (n=%0d) expected 80 (n=1)", dv_at, dv_n); end
      drive_frame(8, 8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 81, -1, 0);
      n_checks++; if (busy_r[1] !== 1'b1 || edge_r[1] != 0) begin n_fail++; $display("FAIL b2b_restart: got busy=%b edge=%0d expected 1/0", busy_r[1], edge_r[1]); end
      n_checks++; if (strt_at != 7) begin n_fail++; $display("FAIL b2b_strt2: got %0d expected 7", strt_at); end
      n_checks++; if (dv_at != 80 || dv_n != 1 || busy_r[81] !== 1'b0) begin n_fail++; $display("FAIL b2b_dv2: got dv=%0d n=%0d busy=%b expected 80/1/0", dv_at, dv_n, busy_r[81]); end
   endtask

   task automatic test_async_reset();
      bit found;
      found = 1'b0;
      prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         rx_in = 1'b1;
         if (busy === 1'b1 && bit_cnt == 4'd4) begin found = 1'b1; break; end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL arst_reach: got bit_cnt=%0d expected 4", bit_cnt); end
      #1;
      rst = 1'b0;
      #1;
      n_checks++; if (out_vec() !== 18'd0) begin n_fail++; $display("FAIL arst_outputs: got %h expected 0", out_vec()); end
      tick();
      n_checks++; if (out_vec() !== 18'd0) begin n_fail++; $display("FAIL arst_held: got %h expected 0", out_vec()); end
      rst = 1'b1;
      tick(); tick();
      drive_frame(8, 8, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 81, -1, 0);
      n_checks++; if (dv_at != 80 || dv_n != 1 || fe_n != 0 || deser_n != 8) begin n_fail++; $display("FAIL arst_recover: got dv=%0d n=%0d fe=%0d deser=%0d expected 80/1/0/8", dv_at, dv_n, fe_n, deser_n); end
   endtask

   task automatic test_prescale();
      drive_frame(8, 8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 81, 3, 32);
      n_checks++; if (strt_at != 7 || deser_at[7] != 71) begin n_fail++; $display("FAIL chg_timing: got strt=%0d deser7=%0d expected 7/71", strt_at, deser_at[7]); end
      n_checks++; if (stp_at != 79 || dv_at != 80 || busy_r[81] !== 1'b0) begin n_fail++; $display("FAIL chg_end: got stp=%0d dv=%0d busy=%b expected 79/80/0", stp_at, dv_at, busy_r[81]); end
      drive_frame(9, 8, 1'b0, 8'h69, 1'b0, 1'b0, 1'b0, 1'b0, 81, -1, 0);
      n_checks++; if (strt_at != 7 || deser_at[0] != 15) begin n_fail++; $display("FAIL odd9_timing: got strt=%0d deser0=%0d expected 7/15", strt_at, deser_at[0]); end
      n_checks++; if (stp_at != 79 || dv_at != 80 || busy_r[81] !== 1'b0) begin n_fail++; $display("FAIL odd9_end: got stp=%0d dv=%0d busy=%b expected 79/80/0", stp_at, dv_at, busy_r[81]); end
      prescale = 6'd8;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_stop_err();
      test_glitch();
      test_back_to_back();
      test_async_reset();
      test_prescale();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequencing FSM for the UART receive path.
- Owns the oversampling edge counter and the bit counter.
- Issues one-cycle enables to the data sampler, deserializer, and the start, parity and stop checkers, then captures their registered error pulses.
- Produces the frame-level data_valid and frm_err strobes consumed by the RX-to-ALU interface.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of the prescale input and of edge_cnt.
- BIT_CNT_W, 4, width of bit_cnt; must hold DATA_WIDTH+2.

Ports:
- clk  in  1  system clock (oversampled, prescale × baud).
- rst  in  1  asynchronous, active-low reset.
- rx_in  in  1  synchronised serial line, idle high.
- prescale  in  PRESCALE_W  oversampling ratio; legal values are even, 8..32.
- par_en  in  1  parity bit present in frame.
- strt_glitch  in  1  start-check error pulse, registered, one cycle after strt_chk_en.
- par_err  in  1  parity-check error pulse, one cycle after par_chk_en.
- stp_err  in  1  stop-check error pulse, one cycle after stp_chk_en; low whenever not enabled.
- edge_cnt  out  PRESCALE_W  oversample index within the current bit.
- bit_cnt  out  BIT_CNT_W  bit index within the frame: 0 = start, 1..DATA_WIDTH = data, then parity if enabled, then stop.
- dat_samp_en  out  1  sampler enable, high in every non-IDLE state.
- strt_chk_en  out  1  one-cycle start-check strobe.
- deser_en  out  1  one-cycle shift strobe per data bit.
- par_chk_en  out  1  one-cycle parity-check strobe.
- stp_chk_en  out  1  one-cycle stop-check strobe.
- data_valid  out  1  one-cycle pulse: good frame received.
- frm_err  out  1  one-cycle pulse: frame failed parity or stop check.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE, every output and all internal registers 0. Reset asserted mid-frame aborts the frame with no data_valid and no frm_err.
- States and entry:
  - IDLE: rx_in==0 sampled → START next cycle. At that transition: edge_cnt=0, bit_cnt=0, prescale latched into p_lat.
  - p_lat: odd or out-of-range prescale is latched as 8. Changes to prescale mid-frame are ignored.
- Edge counter: increments every non-IDLE cycle. Wraps to 0 at p_lat-1 and bit_cnt increments on the wrap.
- Sample point: SP = p_lat/2+2. The sampler's majority result is ready by then.
- Strobes, each asserted for the single cycle with edge_cnt==SP:
  - START: strt_chk_en.
  - DATA: deser_en.
  - PARITY: par_chk_en.
  - STOP: stp_chk_en.
- Error capture: the cycle after each strobe (edge_cnt==SP+1), the controller ORs the matching error input into sticky registers glitch_f and err_f. Error inputs at any other time are ignored.
- START, at edge_cnt==p_lat-1:
  - glitch_f=1 → IDLE with no pulses.
  - Otherwise → DATA, bit_cnt=1.
- DATA, at the end of bit DATA_WIDTH: → PARITY if par_en, else → STOP. par_en is latched with prescale.
- PARITY, at end of bit → STOP.
- STOP, at edge_cnt==p_lat-1:
  - err_f=0 → data_valid=1 for one cycle; err_f=1 → frm_err=1 instead. Never both.
  - Same cycle: rx_in==0 → START with edge_cnt=0, prescale re-latched (back-to-back frame). Otherwise → IDLE.
  - glitch_f and err_f clear.
- Latency: last cycle of the stop bit = T + (bits × p_lat), where T is the IDLE cycle that saw rx_in==0 and bits = DATA_WIDTH+2 (+1 with parity).
- All outputs are registered, or decoded from registered state and counters only. No combinational path from rx_in to outputs.

Decomposition:
- Package uart_rx_pkg:
  - state encoding localparams IDLE, START, DATA, PARITY, STOP;
  - sample-point offset constant 2;
  - default prescale 8 and legal range bounds.
- Sub-module uart_edge_bit_cnt:
  - holds edge_cnt and bit_cnt with enable, wrap at p_lat-1 and synchronous clear;
  - the FSM drives its enable and clear.

Test Plan:
- prescale=8, par_en=0, byte 0xA5 with good stop, rx_in falls at cycle T:
  - strt_chk_en at T+7;
  - deser_en 8 times at T+15, T+23, …, T+71;
  - stp_chk_en at T+79;
  - data_valid one cycle at T+80; busy low at T+81.
- prescale=16, par_en=1, par_err pulsed the cycle after par_chk_en → frm_err=1 at the end of the stop bit, data_valid stays 0, busy clears.
- strt_glitch pulsed at edge_cnt==SP+1 of START → return to IDLE at edge_cnt==p_lat-1, no deser_en/data_valid/frm_err; a new start edge is accepted afterwards.
- Back-to-back frames, prescale=8: rx_in low on the final stop cycle → next cycle in START with edge_cnt=0; both frames give data_valid.
- rst driven low at bit_cnt=4 of DATA → all outputs 0 asynchronously; after release, a full frame is received correctly.
- prescale changed 8→32 mid-frame, and separately prescale=9: the first frame is timed with 8 throughout; prescale=9 behaves identically to 8.
